fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-entry PC/IF-ID path with a decoupled prefetch buffer. It owns the fetch PC, reads the combinational instruction memory every cycle, and pushes {PC+4, instruction} pairs into a DEPTH-entry circular FIFO. Decode drains the FIFO through a valid/ready handshake. Branch and jump resolution redirects the fetch PC and flushes the buffer in one cycle. The block sits between InstructionMemory and the IF/ID consumer.

---
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Decoupled instruction-fetch stage. Owns the fetch PC, reads the
// combinational instruction memory every cycle and pushes {PC+4, instruction}
// pairs into a DEPTH-entry circular FIFO. Decode drains the FIFO with a
// valid/ready handshake. A redirect reloads the fetch PC and flushes the
// buffer in a single cycle.
//
// Ports:
//   Clk         in   1       clock, rising edge
//   Reset       in   1       asynchronous, active-high reset
//   FetchEn     in   1       permit fetch/push this cycle
//   ImemAddr    out  ADDR_W  current fetch PC to instruction memory
//   ImemData    in   DATA_W  instruction at ImemAddr (combinational return)
//   Redirect    in   1       taken branch/jump: flush and reload PC
//   RedirectPC  in   ADDR_W  new fetch PC, bits [1:0] ignored
//   OutValid    out  1       head entry available
//   OutReady    in   1       consumer accepts head
//   OutInstr    out  DATA_W  head instruction
//   OutPCPlus4  out  ADDR_W  head fetch PC + 4
//   Count       out  CNT_W   entries held
//   Full        out  1       Count == DEPTH
//   Empty       out  1       Count == 0
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        CNT_W    = 3,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FetchEn,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic [DATA_W-1:0] ImemData,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutInstr,
    output logic [ADDR_W-1:0] OutPCPlus4,
    output logic [CNT_W-1:0]  Count,
    output logic              Full,
    output logic              Empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    // Registered state
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Entry storage: deliberately not reset, only the control state is.
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0] pc4_q   [DEPTH];

    logic              full;
    logic              empty;
    logic              out_valid;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_pc;

    // Low address bits of the redirect target are forced to zero.
    logic              unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^RedirectPC[1:0];
    assign redirect_pc          = {RedirectPC[ADDR_W-1:2], 2'b00};

    assign pc_plus4 = pc_q + PC_STEP;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // Redirect masks the head combinationally so no pop completes while
    // the buffer is being flushed.
    assign out_valid = ~empty & ~Redirect;
    assign pop       = out_valid & OutReady;

    // A full queue still accepts a push when the head leaves this cycle.
    assign push = FetchEn & ~Redirect & (~full | pop);

    // Next-state logic
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (Redirect) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_plus4;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write
    always_ff @(posedge Clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= ImemData;
            pc4_q[wr_ptr_q]   <= pc_plus4;
        end
    end

    // Outputs: head data comes only from storage, never from ImemData.
    assign ImemAddr   = pc_q;
    assign OutValid   = out_valid;
    assign OutInstr   = instr_q[rd_ptr_q];
    assign OutPCPlus4 = pc4_q[rd_ptr_q];
    assign Count      = count_q;
    assign Full       = full;
    assign Empty      = empty;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with DEPTH = 4. The instruction memory holds
// word i = 0x1000_0000 + i. Inputs change and outputs are sampled on the
// falling clock edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc4;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    int unsigned total;
    int unsigned bad;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W),
        .RESET_PC ('0)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .FetchEn    (fetch_en),
        .ImemAddr   (imem_addr),
        .ImemData   (imem_data),
        .Redirect   (redirect),
        .RedirectPC (redirect_pc),
        .OutValid   (out_valid),
        .OutReady   (out_ready),
        .OutInstr   (out_instr),
        .OutPCPlus4 (out_pc4),
        .Count      (count),
        .Full       (full),
        .Empty      (empty)
    );

    // Instruction memory model
    assign imem_data = 32'h1000_0000 + (imem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'h0);

        // 1: fill to full with no consumer
        rst      = 1'b0;
        fetch_en = 1'b1;
        repeat (4) step();
        check("t1_count", 64'(count), 64'd4);
        check("t1_full", 64'(full), 64'd1);
        check("t1_addr", 64'(imem_addr), 64'h10);
        check("t1_instr", 64'(out_instr), 64'h1000_0000);
        check("t1_pc4", 64'(out_pc4), 64'h4);
        repeat (2) step();
        check("t1_hold_addr", 64'(imem_addr), 64'h10);
        check("t1_hold_count", 64'(count), 64'd4);

        // 2: simultaneous pop and push while full
        out_ready = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            step();
            check("t2_count", 64'(count), 64'd4);
            check("t2_instr", 64'(out_instr), 64'(32'h1000_0000 + i));
            check("t2_pc4", 64'(out_pc4), 64'(4 * (i + 1)));
            check("t2_addr", 64'(imem_addr), 64'(32'h10 + 4 * i));
        end

        // 3: streaming from reset, one instruction per cycle
        out_ready = 1'b1;
        do_reset();
        check("t3_valid0", 64'(out_valid), 64'd0);
        for (int unsigned k = 1; k <= 11; k++) begin
            step();
            check("t3_valid", 64'(out_valid), 64'd1);
            check("t3_pc4", 64'(out_pc4), 64'(4 * k));
            check("t3_count", 64'(count), 64'd1);
        end

        // 4: redirect with Count = 3
        out_ready = 1'b0;
        repeat (2) step();
        check("t4_count3", 64'(count), 64'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        out_ready   = 1'b1;
        #1;
        check("t4_valid_mask", 64'(out_valid), 64'd0);
        step();
        redirect = 1'b0;
        #1;
        check("t4_count0", 64'(count), 64'd0);
        check("t4_addr", 64'(imem_addr), 64'h40);
        check("t4_valid_gap", 64'(out_valid), 64'd0);
        step();
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_instr", 64'(out_instr), 64'h1000_0010);
        check("t4_pc4", 64'(out_pc4), 64'h44);

        // 5: asynchronous reset between edges with Count = 2
        out_ready = 1'b0;
        step();
        check("t5_count2", 64'(count), 64'd2);
        #3;
        rst = 1'b1;
        #1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_addr", 64'(imem_addr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_restart_addr", 64'(imem_addr), 64'h0);
        step();
        check("t5_addr1", 64'(imem_addr), 64'h4);
        check("t5_instr", 64'(out_instr), 64'h1000_0000);
        check("t5_pc4", 64'(out_pc4), 64'h4);

        // 6: FetchEn toggling with a ready consumer
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        check("t6_addr0", 64'(imem_addr), 64'h0);
        step();
        check("t6_addr1", 64'(imem_addr), 64'h4);
        check("t6_valid1", 64'(out_valid), 64'd1);
        fetch_en = 1'b0;
        step();
        check("t6_addr2", 64'(imem_addr), 64'h4);
        check("t6_valid2", 64'(out_valid), 64'd0);
        fetch_en = 1'b1;
        step();
        check("t6_addr3", 64'(imem_addr), 64'h8);
        check("t6_valid3", 64'(out_valid), 64'd1);
        check("t6_pc4", 64'(out_pc4), 64'h8);
        fetch_en = 1'b0;
        step();
        check("t6_addr4", 64'(imem_addr), 64'h8);
        check("t6_valid4", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
